// File: rtl/imem_boot_ctrl_pkg.sv
// Shared sizes, state encoding and helpers for the instruction-memory boot controller.
// Optional build macro: IMEM_CHECKSUM_EN (adds the CHECK/FAIL checksum stage).
package imem_boot_ctrl_pkg;

    localparam int unsigned WORD_SIZE     = 32;
    localparam int unsigned INST_MEM_SIZE = 256;
    localparam int unsigned IMEM_ADDR_W   = $clog2(INST_MEM_SIZE);
    localparam int unsigned CNT_W         = IMEM_ADDR_W + 1;

    localparam logic [WORD_SIZE-1:0] NOP_INSTR = 32'h0;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_FAIL  = 3'd4
    } boot_state_e;

    // Requested lengths beyond the array are truncated; the surplus is never requested.
    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
        return (len > CNT_W'(INST_MEM_SIZE)) ? CNT_W'(INST_MEM_SIZE) : len;
    endfunction

endpackage

// File: rtl/imem_boot_ctrl_word_counter.sv
// Boot word counter: write address during load plus last-word detect against the latched length.
import imem_boot_ctrl_pkg::*;

module imem_boot_ctrl_word_counter (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    input  logic                   inc,
    input  logic [CNT_W-1:0]       len,
    output logic [IMEM_ADDR_W-1:0] addr,
    output logic                   last
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // One extra bit lets the count reach DEPTH without aliasing address 0.
    assign addr = cnt[IMEM_ADDR_W-1:0];
    assign last = (cnt == len - CNT_W'(1));

endmodule

// File: rtl/imem_boot_ctrl.sv
// Owns the instruction-memory port: loads a program from a valid/ready boot stream, then serves fetch.
// Optional build macro: IMEM_CHECKSUM_EN (trailing checksum word verified before RUN).
import imem_boot_ctrl_pkg::*;

module imem_boot_ctrl (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   boot_start,
    input  logic [CNT_W-1:0]       boot_len,
    input  logic                   s_valid,
    input  logic [WORD_SIZE-1:0]   s_data,
    output logic                   s_ready,
    input  logic [WORD_SIZE-1:0]   fetch_addr,
    output logic [WORD_SIZE-1:0]   fetch_instr,
    output logic                   cpu_run,
    output logic                   fetch_fault,
    output logic                   mem_we,
    output logic [IMEM_ADDR_W-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]   mem_wdata,
    input  logic [WORD_SIZE-1:0]   mem_rdata,
    output logic                   done,
    output logic                   err
);

    boot_state_e            state;
    logic [CNT_W-1:0]       len_q;
    logic [IMEM_ADDR_W-1:0] cnt_addr;
    logic                   last;
    logic                   hs;
    logic                   start_ok;
    logic                   in_run;
`ifdef IMEM_CHECKSUM_EN
    logic [WORD_SIZE-1:0]   sum_q;
`endif

    assign hs       = s_valid & s_ready;
    assign in_run   = (state == ST_RUN);
    assign start_ok = boot_start & (state inside {ST_IDLE, ST_RUN, ST_FAIL});

    imem_boot_ctrl_word_counter u_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_ok),
        .inc  (hs & (state == ST_LOAD)),
        .len  (len_q),
        .addr (cnt_addr),
        .last (last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            len_q   <= '0;
            s_ready <= 1'b0;
            cpu_run <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_RUN, ST_FAIL: begin
                    if (boot_start) begin
                        len_q   <= clamp_len(boot_len);
                        err     <= (boot_len > CNT_W'(INST_MEM_SIZE));
                        cpu_run <= 1'b0;
`ifdef IMEM_CHECKSUM_EN
                        sum_q   <= '0;
`endif
                        if (boot_len == '0) begin
`ifdef IMEM_CHECKSUM_EN
                            state   <= ST_CHECK;
                            s_ready <= 1'b1;
`else
                            state   <= ST_RUN;
                            cpu_run <= 1'b1;
                            done    <= 1'b1;
`endif
                        end else begin
                            state   <= ST_LOAD;
                            s_ready <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (hs) begin
`ifdef IMEM_CHECKSUM_EN
                        sum_q <= sum_q + s_data;
                        if (last) begin
                            state <= ST_CHECK;
                        end
`else
                        if (last) begin
                            state   <= ST_RUN;
                            s_ready <= 1'b0;
                            cpu_run <= 1'b1;
                            done    <= 1'b1;
                        end
`endif
                    end
                end
`ifdef IMEM_CHECKSUM_EN
                // Trailing word is compared against the running sum and never written.
                ST_CHECK: begin
                    if (hs) begin
                        s_ready <= 1'b0;
                        if (s_data == sum_q) begin
                            state   <= ST_RUN;
                            cpu_run <= 1'b1;
                            done    <= 1'b1;
                        end else begin
                            state <= ST_FAIL;
                            err   <= 1'b1;
                        end
                    end
                end
`endif
                default: begin
                    state   <= ST_IDLE;
                    s_ready <= 1'b0;
                    cpu_run <= 1'b0;
                end
            endcase
        end
    end

    // Memory port: fetch owns the address in RUN, the boot counter otherwise.
    assign fetch_fault = in_run & (fetch_addr >= WORD_SIZE'(INST_MEM_SIZE));
    assign fetch_instr = (in_run && !fetch_fault) ? mem_rdata : NOP_INSTR;
    assign mem_we      = hs & (state == ST_LOAD);
    assign mem_addr    = in_run ? fetch_addr[IMEM_ADDR_W-1:0] : cnt_addr;
    assign mem_wdata   = s_data;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Randomized self-checking bench for imem_boot_ctrl with an external memory array and a reference image.
module tb_imem_boot_ctrl;
    import imem_boot_ctrl_pkg::*;

    localparam int DEPTH = 256;

    logic        clk, rst, boot_start, s_valid, s_ready;
    logic [8:0]  boot_len;
    logic [31:0] s_data, fetch_addr, fetch_instr, mem_wdata, mem_rdata;
    logic        cpu_run, fetch_fault, mem_we, done, err;
    logic [7:0]  mem_addr;

    imem_boot_ctrl dut (
        .clk(clk), .rst(rst), .boot_start(boot_start), .boot_len(boot_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .fetch_addr(fetch_addr), .fetch_instr(fetch_instr), .cpu_run(cpu_run),
        .fetch_fault(fetch_fault), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External instruction memory: async read, sync write.
    logic [31:0] mem [DEPTH];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    int wr_cnt = 0;
    always @(posedge clk) if (mem_we) wr_cnt++;

    logic [31:0] ref_mem [DEPTH];
    bit          ref_ok  [DEPTH];
    logic [31:0] words [$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic fill_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom);
    endtask

    // Runs one boot of blen words from 'words'; checks handshake, done timing, write count and contents.
    task automatic do_boot(input int blen, input bit gaps, input bit bad_check, input string tag);
        int exp, base, sent, cyc;
        bit early_done, hs, v;
        logic [31:0] sum;
        exp = (blen > DEPTH) ? DEPTH : blen;
        base = wr_cnt; sent = 0; cyc = 0; early_done = 0; sum = 0;
        @(negedge clk); boot_start = 1'b1; boot_len = 9'(blen);
        @(negedge clk); boot_start = 1'b0;
        n_tests++;
        if (s_ready !== 1'b1 || cpu_run !== 1'b0 || err !== (blen > DEPTH)) begin
            n_fail++;
            $display("FAIL %s_start: got ready=%b run=%b err=%b want 1 0 %b", tag, s_ready, cpu_run, err, blen > DEPTH);
        end
        while (sent < exp && cyc < 4000) begin
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_valid = v; s_data = words[sent];
            if (done) early_done = 1;
            hs = v && s_ready;
            @(negedge clk);
            if (hs) begin
                ref_mem[sent] = words[sent]; ref_ok[sent] = 1; sum += words[sent]; sent++;
            end
            cyc++;
        end
        s_valid = 1'b0;
        n_tests++;
        if (sent != exp) begin
            n_fail++; $display("FAIL %s_timeout: got %0d handshakes want %0d", tag, sent, exp);
        end
`ifdef IMEM_CHECKSUM_EN
        n_tests++;
        if (s_ready !== 1'b1 || done !== 1'b0 || cpu_run !== 1'b0) begin
            n_fail++; $display("FAIL %s_check_state: got ready=%b done=%b run=%b want 1 0 0", tag, s_ready, done, cpu_run);
        end
        s_valid = 1'b1; s_data = bad_check ? sum + 32'd1 : sum;
        @(negedge clk); s_valid = 1'b0;
        n_tests++;
        if (bad_check) begin
            if (done !== 1'b0 || cpu_run !== 1'b0 || err !== 1'b1 || s_ready !== 1'b0) begin
                n_fail++; $display("FAIL %s_badsum: got done=%b run=%b err=%b ready=%b want 0 0 1 0", tag, done, cpu_run, err, s_ready);
            end
        end else if (done !== 1'b1 || cpu_run !== 1'b1 || s_ready !== 1'b0) begin
            n_fail++; $display("FAIL %s_goodsum: got done=%b run=%b ready=%b want 1 1 0", tag, done, cpu_run, s_ready);
        end
`else
        n_tests++;
        if (done !== 1'b1 || cpu_run !== 1'b1 || s_ready !== 1'b0 || early_done || bad_check) begin
            n_fail++;
            $display("FAIL %s_done: got done=%b run=%b ready=%b early=%b want 1 1 0 0", tag, done, cpu_run, s_ready, early_done);
        end
`endif
        n_tests++;
        if (wr_cnt - base != exp) begin
            n_fail++; $display("FAIL %s_writes: got %0d want %0d", tag, wr_cnt - base, exp);
        end
        for (int i = 0; i < exp; i++) begin
            if (mem[i] !== words[i]) begin
                n_tests++; n_fail++;
                $display("FAIL %s_mem[%0d]: got %h want %h", tag, i, mem[i], words[i]);
                break;
            end
        end
        @(negedge clk);
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL %s_done_pulse: got %b want 0", tag, done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; fetch_addr = $urandom_range(0, 255);
        repeat (2) @(negedge clk);
        n_tests++;
        if (cpu_run !== 1'b0 || s_ready !== 1'b0 || fetch_instr !== 32'h0 || err !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: got run=%b ready=%b instr=%h err=%b done=%b we=%b want all 0", cpu_run, s_ready, fetch_instr, err, done, mem_we);
        end
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (cpu_run !== 1'b0 || s_ready !== 1'b0 || fetch_fault !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got run=%b ready=%b fault=%b want 0 0 0", cpu_run, s_ready, fetch_fault);
        end
    endtask

    task automatic test_basic_load();
        words.delete();
        for (int i = 0; i < 4; i++) words.push_back(32'h20080001 + 32'(i));
        do_boot(4, 1'b1, 1'b0, "basic");
        fetch_addr = 32'd2; #1;
        n_tests++;
        if (fetch_instr !== 32'h20080003 || fetch_fault !== 1'b0) begin
            n_fail++; $display("FAIL basic_fetch: got %h fault=%b want 20080003 0", fetch_instr, fetch_fault);
        end
    endtask

    task automatic test_fetch_fault();
        @(negedge clk); fetch_addr = 32'd300; #1;
        n_tests++;
        if (fetch_instr !== 32'h0 || fetch_fault !== 1'b1 || cpu_run !== 1'b1) begin
            n_fail++; $display("FAIL fetch_fault: got instr=%h fault=%b run=%b want 0 1 1", fetch_instr, fetch_fault, cpu_run);
        end
    endtask

    task automatic test_overlength();
        fill_words(DEPTH);
        do_boot(300, 1'b0, 1'b0, "overlen");
        repeat (3) @(negedge clk);
        n_tests++;
        if (err !== 1'b1 || cpu_run !== 1'b1 || s_ready !== 1'b0) begin
            n_fail++; $display("FAIL overlen_hold: got err=%b run=%b ready=%b want 1 1 0", err, cpu_run, s_ready);
        end
    endtask

    task automatic test_reset_mid_load();
        int base;
        fill_words(4);
        base = wr_cnt;
        @(negedge clk); boot_start = 1'b1; boot_len = 9'd4;
        @(negedge clk); boot_start = 1'b0;
        s_valid = 1'b1; s_data = words[0];
        @(negedge clk); s_data = words[1];
        @(negedge clk); s_valid = 1'b0; rst = 1'b0; #1;
        n_tests++;
        if (s_ready !== 1'b0 || cpu_run !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0) begin
            n_fail++; $display("FAIL midreset: got ready=%b run=%b done=%b we=%b want 0 0 0 0", s_ready, cpu_run, done, mem_we);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (mem[0] !== words[0] || mem[1] !== words[1] || mem[2] !== ref_mem[2] || mem[3] !== ref_mem[3] || wr_cnt - base != 2) begin
            n_fail++; $display("FAIL midreset_mem: got %h %h %h %h writes=%0d want %h %h %h %h 2",
                mem[0], mem[1], mem[2], mem[3], wr_cnt - base, words[0], words[1], ref_mem[2], ref_mem[3]);
        end
        ref_mem[0] = words[0]; ref_mem[1] = words[1];
    endtask

    task automatic test_idle_valid();
        int base;
        base = wr_cnt;
        s_valid = 1'b1; s_data = $urandom;
        repeat (5) @(negedge clk);
        s_valid = 1'b0;
        n_tests++;
        if (wr_cnt != base || s_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL idle_valid: got writes=%0d ready=%b done=%b want 0 0 0", wr_cnt - base, s_ready, done);
        end
    endtask

    task automatic test_zero_len();
        @(negedge clk); boot_start = 1'b1; boot_len = 9'd0;
        @(negedge clk); boot_start = 1'b0;
        n_tests++;
`ifdef IMEM_CHECKSUM_EN
        if (s_ready !== 1'b1 || cpu_run !== 1'b0) begin
            n_fail++; $display("FAIL zero_len: got ready=%b run=%b want 1 0", s_ready, cpu_run);
        end
        s_valid = 1'b1; s_data = 32'h0;
        @(negedge clk); s_valid = 1'b0;
        n_tests++;
`endif
        if (done !== 1'b1 || cpu_run !== 1'b1 || s_ready !== 1'b0) begin
            n_fail++; $display("FAIL zero_len_done: got done=%b run=%b ready=%b want 1 1 0", done, cpu_run, s_ready);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, want;
        for (int r = 0; r < 6; r++) begin
            fill_words($urandom_range(1, 24));
            do_boot(words.size(), 1'(($urandom_range(0, 1))), 1'b0, "rand");
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(256, 100000)) : 32'($urandom_range(0, 255));
                fetch_addr = a; #1;
                want = (a < 32'(DEPTH)) ? ref_mem[a[7:0]] : 32'h0;
                n_tests++;
                if (fetch_instr !== want || fetch_fault !== (a >= 32'(DEPTH))) begin
                    n_fail++; $display("FAIL rand_fetch[%0d]: got %h fault=%b want %h %b", a, fetch_instr, fetch_fault, want, a >= 32'(DEPTH));
                end
            end
        end
    endtask

`ifdef IMEM_CHECKSUM_EN
    task automatic test_checksum();
        words.delete();
        words.push_back(32'd1); words.push_back(32'd2); words.push_back(32'd3);
        do_boot(3, 1'b0, 1'b0, "cksum_ok");
        do_boot(3, 1'b1, 1'b1, "cksum_bad");
        repeat (2) @(negedge clk);
        n_tests++;
        if (cpu_run !== 1'b0 || err !== 1'b1) begin
            n_fail++; $display("FAIL cksum_fail_hold: got run=%b err=%b want 0 1", cpu_run, err);
        end
        @(negedge clk); boot_start = 1'b1; boot_len = 9'd3;
        @(negedge clk); boot_start = 1'b0;
        n_tests++;
        if (err !== 1'b0 || s_ready !== 1'b1) begin
            n_fail++; $display("FAIL cksum_restart: got err=%b ready=%b want 0 1", err, s_ready);
        end
    endtask
`endif

    initial begin
        rst = 1'b0; boot_start = 1'b0; boot_len = '0; s_valid = 1'b0; s_data = '0; fetch_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = 'x; ref_ok[i] = 0; end
        test_reset();
        test_basic_load();
        test_fetch_fault();
        test_overlength();
        test_reset_mid_load();
        test_idle_valid();
        test_zero_len();
        test_random();
`ifdef IMEM_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
